lane_map_mux: RTL and testbench



---
 rtl/lane_map_pkg.sv | 32 +++
 rtl/lane_map_if.sv | 37 +++
 rtl/lane_map_mux_scan.sv | 125 ++++++++++++
 rtl/lane_map_mux.sv | 82 ++++++++
 tb/tb_lane_map_mux.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lane_map_pkg.sv
// -----------------------------------------------------------------------------
// lane_map_pkg
// Shared types and constants for the lane-mapping multiplexer.
//   lm_state_e : map-computation FSM states (LM_IDLE, LM_SCAN, LM_CHECK)
//   lm_clog2   : ceiling log2 helper, never returns less than 1 so that
//                degenerate parameters still yield legal vector widths
//   LM_N_IN / LM_N_OUT / LM_LANE_W : default geometry (70 in, 128 out, 196 b)
// -----------------------------------------------------------------------------
package lane_map_pkg;

    typedef enum logic [1:0] {
        LM_IDLE  = 2'd0,
        LM_SCAN  = 2'd1,
        LM_CHECK = 2'd2
    } lm_state_e;

    localparam int LM_N_IN   = 70;
    localparam int LM_N_OUT  = 128;
    localparam int LM_LANE_W = 196;

    function automatic int lm_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lane_map_if.sv
// -----------------------------------------------------------------------------
// lane_map_if
// Bundles the lane-mapping multiplexer's data and configuration signals.
//   data_in   : N_IN lanes of LANE_W bits, lane i at [i*LANE_W +: LANE_W]
//   sw_in     : requested output enable vector (bit j enables output lane j)
//   sw_load   : request to capture sw_in and recompute the map
//   sw_busy   : map computation in progress
//   sw_err    : last request rejected (popcount(sw_in) != N_IN)
//   map_valid : a validated map is active
//   data_out  : N_OUT lanes of LANE_W bits, lane j at [j*LANE_W +: LANE_W]
// Modports: master drives data/config, slave is the multiplexer.
// -----------------------------------------------------------------------------
interface lane_map_if
    import lane_map_pkg::*;
#(
    parameter int N_IN   = LM_N_IN,
    parameter int N_OUT  = LM_N_OUT,
    parameter int LANE_W = LM_LANE_W
);
    logic [N_IN*LANE_W-1:0]  data_in;
    logic [N_OUT-1:0]        sw_in;
    logic                    sw_load;
    logic                    sw_busy;
    logic                    sw_err;
    logic                    map_valid;
    logic [N_OUT*LANE_W-1:0] data_out;

    modport master (
        output data_in, sw_in, sw_load,
        input  sw_busy, sw_err, map_valid, data_out
    );

    modport slave (
        input  data_in, sw_in, sw_load,
        output sw_busy, sw_err, map_valid, data_out
    );
endinterface

// File: rtl/lane_map_mux_scan.sv
// -----------------------------------------------------------------------------
// lane_map_scan
// Map-computation engine: captures the requested enable vector into a shadow
// register, walks the output lanes one per cycle assigning ascending input
// indices to enabled lanes, then either commits the pending map atomically or
// flags an error.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   sw_in_i        : requested enable vector
//   sw_load_i      : load request (ignored while busy)
//   sw_busy_o      : computation in progress
//   sw_err_o       : last request rejected
//   map_valid_o    : a validated map is active
//   active_en_o    : per-output-lane enable of the active map
//   active_sel_o   : per-output-lane input index, packed SEL_W bits per lane
// -----------------------------------------------------------------------------
module lane_map_scan
    import lane_map_pkg::*;
#(
    parameter int N_IN  = LM_N_IN,
    parameter int N_OUT = LM_N_OUT,
    parameter int SEL_W = lm_clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_OUT-1:0]       sw_in_i,
    input  logic                   sw_load_i,
    output logic                   sw_busy_o,
    output logic                   sw_err_o,
    output logic                   map_valid_o,
    output logic [N_OUT-1:0]       active_en_o,
    output logic [N_OUT*SEL_W-1:0] active_sel_o
);
    localparam int K_W = lm_clog2(N_IN + 1);
    localparam int J_W = lm_clog2(N_OUT);
    localparam logic [K_W-1:0] K_FULL = K_W'(N_IN);
    localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT - 1);

    lm_state_e        state_q;
    logic [N_OUT-1:0] shadow_q;
    logic [N_OUT-1:0] pending_en_q;
    logic [N_OUT-1:0] active_en_q;
    logic [SEL_W-1:0] pending_sel_q [N_OUT];
    logic [SEL_W-1:0] active_sel_q  [N_OUT];
    logic [J_W-1:0]   j_q;
    logic [K_W-1:0]   k_q;
    logic             ovf_q;
    logic             busy_q;
    logic             err_q;
    logic             valid_q;

    // Shadow, pending and select registers need no reset: they are always
    // written before being consumed, and active_en gates every select.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LM_IDLE;
            active_en_q <= '0;
            j_q         <= '0;
            k_q         <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            case (state_q)
                LM_IDLE: begin
                    if (sw_load_i) begin
                        shadow_q <= sw_in_i;
                        j_q      <= '0;
                        k_q      <= '0;
                        ovf_q    <= 1'b0;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= LM_SCAN;
                    end
                end
                LM_SCAN: begin
                    if (shadow_q[j_q]) begin
                        if (k_q != K_FULL) begin
                            // k < N_IN here, so it always fits in SEL_W bits
                            pending_sel_q[j_q] <= k_q[SEL_W-1:0];
                            pending_en_q[j_q]  <= 1'b1;
                            k_q                <= k_q + K_W'(1);
                        end else begin
                            ovf_q              <= 1'b1;
                            pending_en_q[j_q]  <= 1'b0;
                        end
                    end else begin
                        pending_en_q[j_q] <= 1'b0;
                    end
                    if (j_q == J_LAST) begin
                        state_q <= LM_CHECK;
                    end else begin
                        j_q <= j_q + J_W'(1);
                    end
                end
                LM_CHECK: begin
                    // Whole-map copy in one edge: outputs never see a mix
                    if (k_q == K_FULL && !ovf_q) begin
                        active_sel_q <= pending_sel_q;
                        active_en_q  <= pending_en_q;
                        valid_q      <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= LM_IDLE;
                end
                default: begin
                    state_q <= LM_IDLE;
                end
            endcase
        end
    end

    assign sw_busy_o   = busy_q;
    assign sw_err_o    = err_q;
    assign map_valid_o = valid_q;
    assign active_en_o = active_en_q;

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_sel_pack
        assign active_sel_o[gi*SEL_W +: SEL_W] = active_sel_q[gi];
    end

endmodule

// File: rtl/lane_map_mux.sv
// -----------------------------------------------------------------------------
// lane_map_mux
// Routes N_IN input lanes onto the enabled subset of N_OUT output lanes in
// ascending order (k-th enabled output carries input k). Output is registered;
// disabled lanes output 0.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   lm  : lane_map_if.slave (data_in, sw_in, sw_load, sw_busy, sw_err,
//         map_valid, data_out)
// Build option: LANE_MAP_PIPE2_EN adds a second output register stage
// (datapath latency 2); both stages reset to 0.
// -----------------------------------------------------------------------------
module lane_map_mux
    import lane_map_pkg::*;
#(
    parameter int N_IN   = LM_N_IN,
    parameter int N_OUT  = LM_N_OUT,
    parameter int LANE_W = LM_LANE_W
) (
    input  logic     clk,
    input  logic     rst,
    lane_map_if.slave lm
);
    localparam int SEL_W = lm_clog2(N_IN);

    logic [N_OUT-1:0]        active_en;
    logic [N_OUT*SEL_W-1:0]  active_sel;
    logic [LANE_W-1:0]       in_lane [N_IN];
    logic [N_OUT*LANE_W-1:0] data_d;
    logic [N_OUT*LANE_W-1:0] data_q;

    lane_map_scan #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) u_scan (
        .clk          (clk),
        .rst          (rst),
        .sw_in_i      (lm.sw_in),
        .sw_load_i    (lm.sw_load),
        .sw_busy_o    (lm.sw_busy),
        .sw_err_o     (lm.sw_err),
        .map_valid_o  (lm.map_valid),
        .active_en_o  (active_en),
        .active_sel_o (active_sel)
    );

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_in_lane
        assign in_lane[gi] = lm.data_in[gi*LANE_W +: LANE_W];
    end

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out_mux
        assign data_d[gi*LANE_W +: LANE_W] =
            active_en[gi] ? in_lane[active_sel[gi*SEL_W +: SEL_W]] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

`ifdef LANE_MAP_PIPE2_EN
    logic [N_OUT*LANE_W-1:0] data2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data2_q <= '0;
        end else begin
            data2_q <= data_q;
        end
    end

    assign lm.data_out = data2_q;
`else
    assign lm.data_out = data_q;
`endif

endmodule

// File: tb/tb_lane_map_mux.sv
module tb_lane_map_mux;
    import lane_map_pkg::*;

    localparam int N_IN   = LM_N_IN;
    localparam int N_OUT  = LM_N_OUT;
    localparam int LANE_W = LM_LANE_W;
`ifdef LANE_MAP_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lane_map_if #(.N_IN(N_IN), .N_OUT(N_OUT), .LANE_W(LANE_W)) lm_bus ();

    lane_map_mux #(.N_IN(N_IN), .N_OUT(N_OUT), .LANE_W(LANE_W)) dut (
        .clk (clk),
        .rst (rst),
        .lm  (lm_bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: active map as "output j carries input model_map[j]" (-1 = off)
    int   model_map [N_OUT];
    logic model_valid;
    logic model_err;
    logic [N_IN*LANE_W-1:0] din;

    task automatic check(input string tag, input logic [LANE_W-1:0] got,
                         input logic [LANE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        check(tag, LANE_W'(got), LANE_W'(exp));
    endtask

    function automatic logic [LANE_W-1:0] exp_lane(input int j);
        if (model_map[j] < 0) return '0;
        return din[model_map[j]*LANE_W +: LANE_W];
    endfunction

    task automatic check_lanes(input string tag);
        for (int j = 0; j < N_OUT; j++) begin
            check($sformatf("%s.lane%0d", tag, j),
                  lm_bus.data_out[j*LANE_W +: LANE_W], exp_lane(j));
        end
    endtask

    // Compacted ascending routing; accepted only if popcount == N_IN
    task automatic model_load(input logic [N_OUT-1:0] vec);
        int m [N_OUT];
        int ones;
        ones = 0;
        for (int j = 0; j < N_OUT; j++) begin
            m[j] = -1;
            if (vec[j]) begin
                if (ones < N_IN) m[j] = ones;
                ones++;
            end
        end
        if (ones == N_IN) begin
            model_map   = m;
            model_valid = 1'b1;
            model_err   = 1'b0;
        end else begin
            model_err = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < N_OUT; j++) model_map[j] = -1;
        model_valid = 1'b0;
        model_err   = 1'b0;
    endtask

    task automatic rand_din();
        for (int b = 0; b < N_IN*LANE_W; b++) din[b] = 1'($urandom & 1);
        lm_bus.data_in = din;
    endtask

    function automatic logic [N_OUT-1:0] rand_vec();
        logic [N_OUT-1:0] v;
        for (int b = 0; b < N_OUT; b++) v[b] = 1'($urandom & 1);
        return v;
    endfunction

    function automatic logic [N_OUT-1:0] vec_with_ones(input int n);
        logic [N_OUT-1:0] v;
        int cnt;
        int idx;
        v   = '0;
        cnt = 0;
        while (cnt < n) begin
            idx = $urandom_range(0, N_OUT-1);
            if (!v[idx]) begin
                v[idx] = 1'b1;
                cnt++;
            end
        end
        return v;
    endfunction

    // One complete request; sw_in is scrambled during the scan, and optional
    // extra sw_load pulses land mid-scan and on the CHECK edge.
    task automatic do_load(input string tag, input logic [N_OUT-1:0] vec, input bit poke);
        int busy_cnt;
        int late_busy;
        busy_cnt  = 0;
        late_busy = 0;
        @(negedge clk);
        lm_bus.sw_in   = vec;
        lm_bus.sw_load = 1'b1;
        @(negedge clk);                       // after edge t
        lm_bus.sw_load = 1'b0;
        check_bit({tag, ".err_cleared"}, lm_bus.sw_err, 1'b0);
        for (int c = 1; c <= N_OUT + 1; c++) begin
            if (lm_bus.sw_busy) busy_cnt++;
            if (c == N_OUT + 1) begin          // after edge t+N_OUT: not yet decided
                check_bit({tag, ".err_before_check"}, lm_bus.sw_err, 1'b0);
                check_bit({tag, ".valid_before_check"}, lm_bus.map_valid, model_valid);
            end
            lm_bus.sw_in   = rand_vec();
            lm_bus.sw_load = poke && (c == 10 || c == N_OUT + 1);
            @(negedge clk);
        end
        lm_bus.sw_load = 1'b0;                // now after edge t+N_OUT+1
        check({tag, ".busy_cycles"}, LANE_W'(busy_cnt), LANE_W'(N_OUT + 1));
        check_bit({tag, ".busy_done"}, lm_bus.sw_busy, 1'b0);
        repeat (LAT - 1) @(negedge clk);
        check_lanes({tag, ".old"});
        model_load(vec);
        check_bit({tag, ".err"}, lm_bus.sw_err, model_err);
        check_bit({tag, ".valid"}, lm_bus.map_valid, model_valid);
        @(negedge clk);
        check_lanes({tag, ".new"});
        repeat (4) begin
            if (lm_bus.sw_busy) late_busy++;
            @(negedge clk);
        end
        check({tag, ".no_requeue"}, LANE_W'(late_busy), '0);
    endtask

    initial begin
        logic [N_OUT-1:0] sv;
        logic [LANE_W-1:0] ones_lane;
        logic [LANE_W-1:0] old0;

        lm_bus.sw_load = 1'b0;
        lm_bus.sw_in   = '0;
        din            = '0;
        lm_bus.data_in = din;
        model_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_bit("rst.busy", lm_bus.sw_busy, 1'b0);
        check_bit("rst.err", lm_bus.sw_err, 1'b0);
        check_bit("rst.valid", lm_bus.map_valid, 1'b0);
        check_lanes("rst");
        rst = 1'b0;

        // Split map: outputs 2..64 and 121..127, only input lane 5 all-ones
        ones_lane = '1;
        din = '0;
        din[5*LANE_W +: LANE_W] = ones_lane;
        lm_bus.data_in = din;
        sv = '0;
        for (int j = 2; j <= 64; j++) sv[j] = 1'b1;
        for (int j = 121; j <= 127; j++) sv[j] = 1'b1;
        do_load("split", sv, 1'b0);
        check("split.out7_ones", lm_bus.data_out[7*LANE_W +: LANE_W], ones_lane);
        check("split.out6_zero", lm_bus.data_out[6*LANE_W +: LANE_W], '0);

        // Fixed correspondences of the split map with random data
        rand_din();
        repeat (LAT) @(negedge clk);
        check("split.o2_i0", lm_bus.data_out[2*LANE_W +: LANE_W], din[0 +: LANE_W]);
        check("split.o64_i62", lm_bus.data_out[64*LANE_W +: LANE_W], din[62*LANE_W +: LANE_W]);
        check("split.o121_i63", lm_bus.data_out[121*LANE_W +: LANE_W], din[63*LANE_W +: LANE_W]);
        check("split.o127_i69", lm_bus.data_out[127*LANE_W +: LANE_W], din[69*LANE_W +: LANE_W]);
        check("split.o0_zero", lm_bus.data_out[0 +: LANE_W], '0);

        // Latency: toggle input lane 0, watch mapped output lane 2
        old0 = din[0 +: LANE_W];
        din[0 +: LANE_W] = ~old0;
        lm_bus.data_in = din;
        for (int e = 1; e <= LAT; e++) begin
            @(negedge clk);
            check($sformatf("latency.edge%0d", e), lm_bus.data_out[2*LANE_W +: LANE_W],
                  (e < LAT) ? old0 : ~old0);
        end

        // Random valid map with sw_load pokes while busy
        rand_din();
        do_load("rand_busy", vec_with_ones(N_IN), 1'b1);

        // Too few enables
        do_load("bad_count", vec_with_ones(N_IN - 1), 1'b0);

        // Too many enables (overflow)
        sv = '1;
        do_load("overflow", sv, 1'b0);

        // Good request clears the error
        rand_din();
        do_load("recover", vec_with_ones(N_IN), 1'b0);

        // Reset mid-scan aborts and clears everything
        @(negedge clk);
        lm_bus.sw_in   = vec_with_ones(N_IN);
        lm_bus.sw_load = 1'b1;
        @(negedge clk);
        lm_bus.sw_load = 1'b0;
        repeat (50) @(negedge clk);
        check_bit("abort.busy_mid", lm_bus.sw_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_bit("abort.busy", lm_bus.sw_busy, 1'b0);
        check_bit("abort.err", lm_bus.sw_err, 1'b0);
        check_bit("abort.valid", lm_bus.map_valid, 1'b0);
        check_lanes("abort");
        rst = 1'b0;

        // Engine usable again after abort
        rand_din();
        do_load("post_rst", vec_with_ones(N_IN), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
